// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with stall hold buffer, pending redirect and IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PC_MUX_sel,
  input  logic [31:0] NPC_in,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] InstrD,
  output logic [31:0] PC4_D,
  output logic        ValidD
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
  logic [31:0] hold_q, hold_d, pend_pc_q, pend_pc_d;
  logic        valid_q, valid_d, pend_v_q, pend_v_d;
  logic [31:0] pc_plus4, next_pc, word;
  logic        load;
  assign pc_plus4  = pc_q + 32'd4;
  assign next_pc   = (PC_MUX_sel & ~stall) ? NPC_in : pend_v_q ? pend_pc_q : pc_plus4;
  assign load      = ~stall & (state_q == HOLD | imem_ready);
  assign word      = (state_q == HOLD) ? hold_q : imem_rdata;
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PC4_D     = pc4_q;
  assign ValidD    = valid_q;
  // Next-state: deliver a word, park a word behind a stall, or insert a bubble and remember a redirect
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    pend_pc_d = pend_pc_q;
    pend_v_d  = pend_v_q;
    if (load) begin
      instr_d  = word;
      pc4_d    = pc_plus4;
      valid_d  = 1'b1;
      pc_d     = next_pc;
      pend_v_d = 1'b0;
      state_d  = FETCH;
    end else if (state_q == FETCH && imem_ready) begin
      hold_d  = imem_rdata;
      state_d = HOLD;
    end else if (state_q == FETCH && !stall) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (PC_MUX_sel) begin
        pend_pc_d = NPC_in;
        pend_v_d  = 1'b1;
      end
    end
  end
  // State registers; reset discards any held word and pending target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      pc4_q     <= 32'd0;
      valid_q   <= 1'b0;
      hold_q    <= 32'd0;
      pend_pc_q <= 32'd0;
      pend_v_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      pend_pc_q <= pend_pc_d;
      pend_v_q  <= pend_v_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage against a queue-based fetch model
module tb_if_stage;
  localparam logic [31:0] RPC = 32'h0000_3000;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, PC_MUX_sel = 1'b0, imem_ready = 1'b0;
  logic [31:0] NPC_in = 32'd0, imem_rdata = 32'd0;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PC4_D;
  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PC_MUX_sel(PC_MUX_sel), .NPC_in(NPC_in),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
    .imem_addr(imem_addr), .InstrD(InstrD), .PC4_D(PC4_D), .ValidD(ValidD)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } obs_t;
  obs_t sbq[$];
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] held[$];
  logic [31:0] redir[$];
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  function automatic obs_t expect_now();
    obs_t e;
    e.req = (held.size() == 0);
    e.addr = m_pc;
    e.instr = m_instr;
    e.pc4 = m_pc4;
    e.valid = m_valid;
    return e;
  endfunction
  function automatic obs_t dut_obs();
    obs_t o;
    o.req = imem_req;
    o.addr = imem_addr;
    o.instr = InstrD;
    o.pc4 = PC4_D;
    o.valid = ValidD;
    return o;
  endfunction
  task automatic check(input string nm, input obs_t got, input obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got req=%b addr=%h instr=%h pc4=%h valid=%b, expected req=%b addr=%h instr=%h pc4=%h valid=%b",
               nm, $time, got.req, got.addr, got.instr, got.pc4, got.valid, exp.req, exp.addr, exp.instr, exp.pc4, exp.valid);
    end
  endtask
  task automatic model_reset();
    m_pc = RPC;
    m_instr = 32'd0;
    m_pc4 = 32'd0;
    m_valid = 1'b0;
    held.delete();
    redir.delete();
  endtask
  task automatic step(input logic st, input logic sel, input logic [31:0] npc, input logic rdy);
    logic [31:0] nxt, w;
    logic deliver;
    stall = st;
    PC_MUX_sel = sel;
    NPC_in = npc;
    imem_ready = rdy;
    imem_rdata = (held.size() == 0) ? word_at(m_pc) : $urandom;
    @(posedge clk);
    nxt = (sel && !st) ? npc : (redir.size() != 0 ? redir[0] : m_pc + 32'd4);
    deliver = 1'b0;
    w = 32'd0;
    if (held.size() != 0) begin
      if (!st) begin
        w = held.pop_front();
        deliver = 1'b1;
      end
    end else if (rdy && !st) begin
      w = word_at(m_pc);
      deliver = 1'b1;
    end else if (rdy) begin
      held.push_back(word_at(m_pc));
    end else if (!st) begin
      m_instr = 32'd0;
      m_pc4 = 32'd0;
      m_valid = 1'b0;
      if (sel) begin
        redir.delete();
        redir.push_back(npc);
      end
    end
    if (deliver) begin
      m_instr = w;
      m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc = nxt;
      redir.delete();
    end
    sbq.push_back(expect_now());
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_async", dut_obs(), expect_now());
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_held", dut_obs(), expect_now());
    reset = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (sbq.size() != 0) check("cycle", dut_obs(), sbq.pop_front());
  end
  initial begin
    logic [31:0] npc;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", dut_obs(), expect_now());
    reset = 1'b0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h0000_3100, 1);
    step(0, 1, 32'h0000_3010, 1);
    repeat (3) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h0000_3200, 0);
    step(0, 1, 32'h0000_3200, 0);
    step(0, 0, 0, 1);
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 1, 32'h0000_4000, 0);
    do_reset();
    repeat (3) step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: npc = 32'hFFFF_FFFC;
        1: npc = $urandom;
        default: npc = RPC + ($urandom_range(0, 255) << 2);
      endcase
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0, npc, $urandom_range(0, 9) < 7);
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  hazard-unit stall; 1 = hold PC and the IF/ID register.
REQ-005 SHALL have port PC_MUX_sel  input  1  decode-stage redirect request; sampled only when stall=0.
REQ-006 SHALL have port NPC_in  input  32  redirect target from decode.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-008 SHALL have port imem_ready  input  1  memory completes the current request this cycle.
REQ-009 SHALL have port imem_req  output  1  fetch request, held until imem_ready.
REQ-010 SHALL have port imem_addr  output  32  fetch address, equal to the PC register.
REQ-011 SHALL have port InstrD  output  32  IF/ID instruction to decode; 0 (nop) when invalid.
REQ-012 SHALL have port PC4_D  output  32  IF/ID fetch PC + 4.
REQ-013 SHALL have port ValidD  output  1  IF/ID holds a real instruction.

Function
REQ-014 SHALL implement a two-state FSM: FETCH (imem_req=1) and HOLD (imem_req=0); imem_req and imem_addr SHALL be driven from registers and state only.
REQ-015 SHALL compute next_pc with priority (PC_MUX_sel & ~stall) ? NPC_in : pend_v ? pend_pc : PC+4.
REQ-016 FETCH, imem_ready=1, stall=0: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= next_pc; pend_v <= 0; stay in FETCH.
REQ-017 FETCH, imem_ready=1, stall=1: hold_buf <= imem_rdata; IF/ID unchanged; PC unchanged; go to HOLD.
REQ-018 FETCH, imem_ready=0, stall=0: IF/ID <= {0, 0, valid=0} (bubble); PC unchanged; if PC_MUX_sel=1, pend_pc <= NPC_in and pend_v <= 1.
REQ-019 FETCH, imem_ready=0, stall=1: IF/ID, PC and pending registers unchanged.
REQ-020 HOLD, stall=1: all state unchanged; imem_req=0.
REQ-021 HOLD, stall=0: IF/ID <= {hold_buf, PC+4, valid=1}; PC <= next_pc; pend_v <= 0; go to FETCH.
REQ-022 SHALL preserve the branch delay slot: a redirect changes only the PC that follows the instruction currently being fetched, never that instruction itself.
REQ-023 A new redirect arriving while pend_v=1 SHALL overwrite pend_pc; the newest target wins.
REQ-024 SHALL compute PC+4 modulo 2^32; 32'hFFFF_FFFC + 4 = 0, with no trap.
REQ-025 SHALL perform no alignment checking; imem_addr bits [1:0] SHALL follow the PC.
REQ-026 SHALL fetch with a latency of 1 cycle from request to IF/ID when imem_ready=1 in the request cycle, giving a throughput of 1 instruction per cycle.

Reset
REQ-027 While reset=1 (asynchronous): PC=RESET_PC, state=FETCH, InstrD=0, PC4_D=0, ValidD=0, hold_buf=0, pend_v=0, pend_pc=0.
REQ-028 The first rising edge after reset deasserts SHALL operate normally; imem_req=1 with imem_addr=RESET_PC.
REQ-029 Reset asserted mid-HOLD or with a pending redirect SHALL discard the buffered instruction and the target.

Verification
REQ-030 Reset release, imem_ready tied 1, rdata=addr -> InstrD sequence 3000,3004,3008; PC4_D = InstrD+4; ValidD=1 from the first edge.
REQ-031 Branch in D at fetch PC 0x3008 with PC_MUX_sel=1, NPC_in=0x3100 -> delay slot 0x3008 delivered, next imem_addr=0x3100.
REQ-032 Fetch 0x3010 completes with stall=1 for 3 cycles -> FSM goes to HOLD, imem_req=0, IF/ID frozen; on release InstrD=word@0x3010, next addr 0x3014.
REQ-033 imem_ready=0 for 2 cycles while PC_MUX_sel=1, NPC_in=0x3200 -> ValidD=0 bubbles; after completion, next imem_addr=0x3200 (pending path).
REQ-034 PC=0xFFFF_FFFC, fetch completes -> PC4_D=0, next imem_addr=0.
REQ-035 Assert reset asynchronously during HOLD -> outputs cleared immediately without waiting for clk; after release, fetch restarts at 0x3000.
